// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the five-stage MIPS pipeline.
//
// Holds one retiring instruction from MEM. A non-load retires in the cycle
// after capture. A load waits for its AXI read beat, which is aligned and
// extended (including LWL/LWR merge) before the register-file write.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   ms_to_ws_valid / ws_allowin  MEM->WB instruction handshake
//   ms_pc, ms_reg_we, ms_dest,
//   ms_alu_result, ms_load_op,
//   ms_rt_value                  fields of the offered instruction
//   data_rdata_valid/_ready      AXI read-response handshake, data_rdata
//   rf_wen/_waddr/_wdata         register-file write port
//   ws_fwd_*                     forwarding / interlock information for ID
//   load_wait_cnt                total cycles spent waiting for load data
//   debug_wb_*                   retirement trace port
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. MEM->WB uses ms_to_ws_valid/ws_allowin; the read response uses
// data_rdata_valid/data_rdata_ready. A response beat offered while
// data_rdata_ready is 0 is neither consumed nor remembered.
module wb_stage #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ms_to_ws_valid,
    output logic                 ws_allowin,
    input  logic [31:0]          ms_pc,
    input  logic                 ms_reg_we,
    input  logic [4:0]           ms_dest,
    input  logic [31:0]          ms_alu_result,
    input  logic [2:0]           ms_load_op,
    input  logic [31:0]          ms_rt_value,
    input  logic                 data_rdata_valid,
    output logic                 data_rdata_ready,
    input  logic [31:0]          data_rdata,
    output logic                 rf_wen,
    output logic [4:0]           rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 ws_fwd_valid,
    output logic                 ws_fwd_pending,
    output logic [4:0]           ws_fwd_dest,
    output logic [31:0]          ws_fwd_data,
    output logic [CNT_WIDTH-1:0] load_wait_cnt,
    output logic [31:0]          debug_wb_pc,
    output logic [3:0]           debug_wb_rf_wen,
    output logic [4:0]           debug_wb_rf_wnum,
    output logic [31:0]          debug_wb_rf_wdata
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_r;
    logic        reg_we_r;
    logic [4:0]  dest_r;
    logic [31:0] alu_r;
    logic [2:0]  load_op_r;
    logic [31:0] rt_r;

    logic        retire;
    logic        capture;
    logic [1:0]  a;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign retire           = (state == S_HOLD) || (state == S_WAIT && data_rdata_valid);
    assign ws_allowin       = (state == S_EMPTY) || retire;
    assign capture          = ms_to_ws_valid && ws_allowin;
    assign data_rdata_ready = (state == S_WAIT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= S_EMPTY;
            pc_r          <= '0;
            reg_we_r      <= 1'b0;
            dest_r        <= '0;
            alu_r         <= '0;
            load_op_r     <= '0;
            rt_r          <= '0;
            load_wait_cnt <= '0;
        end else begin
            // A stall cycle is a WAIT cycle with no beat; the beat cycle
            // itself is the retire cycle and is not counted.
            if (state == S_WAIT && !data_rdata_valid)
                load_wait_cnt <= load_wait_cnt + CNT_WIDTH'(1);
            if (capture) begin
                pc_r      <= ms_pc;
                reg_we_r  <= ms_reg_we;
                dest_r    <= ms_dest;
                alu_r     <= ms_alu_result;
                load_op_r <= ms_load_op;
                rt_r      <= ms_rt_value;
                state     <= (ms_load_op == 3'd0) ? S_HOLD : S_WAIT;
            end else if (retire) begin
                state     <= S_EMPTY;
            end
        end
    end

    // Load alignment: data_rdata is the whole aligned word, a selects lanes.
    assign a = alu_r[1:0];

    always_comb begin
        byte_sel = data_rdata[7:0];
        case (a)
            2'd0: byte_sel = data_rdata[7:0];
            2'd1: byte_sel = data_rdata[15:8];
            2'd2: byte_sel = data_rdata[23:16];
            2'd3: byte_sel = data_rdata[31:24];
            default: byte_sel = data_rdata[7:0];
        endcase
    end

    assign half_sel = a[1] ? data_rdata[31:16] : data_rdata[15:0];

    always_comb begin
        load_data = data_rdata;
        case (load_op_r)
            3'd1: load_data = data_rdata;
            3'd2: load_data = {{24{byte_sel[7]}}, byte_sel};
            3'd3: load_data = {24'd0, byte_sel};
            3'd4: load_data = {{16{half_sel[15]}}, half_sel};
            3'd5: load_data = {16'd0, half_sel};
            3'd6: begin
                case (a)
                    2'd0: load_data = {data_rdata[7:0],  rt_r[23:0]};
                    2'd1: load_data = {data_rdata[15:0], rt_r[15:0]};
                    2'd2: load_data = {data_rdata[23:0], rt_r[7:0]};
                    default: load_data = data_rdata;
                endcase
            end
            3'd7: begin
                case (a)
                    2'd1: load_data = {rt_r[31:24], data_rdata[31:8]};
                    2'd2: load_data = {rt_r[31:16], data_rdata[31:16]};
                    2'd3: load_data = {rt_r[31:8],  data_rdata[31:24]};
                    default: load_data = data_rdata;
                endcase
            end
            default: load_data = data_rdata;
        endcase
    end

    assign rf_wen   = retire && reg_we_r && (dest_r != 5'd0);
    assign rf_waddr = dest_r;
    assign rf_wdata = (load_op_r == 3'd0) ? alu_r : load_data;

    assign ws_fwd_dest    = (state != S_EMPTY && reg_we_r && dest_r != 5'd0) ? dest_r : 5'd0;
    assign ws_fwd_pending = (state == S_WAIT) && !data_rdata_valid && (ws_fwd_dest != 5'd0);
    assign ws_fwd_valid   = (ws_fwd_dest != 5'd0) && !ws_fwd_pending;
    assign ws_fwd_data    = rf_wdata;

    assign debug_wb_pc       = retire ? pc_r : 32'd0;
    assign debug_wb_rf_wen   = {4{rf_wen}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage. Inputs change 1 ns after a rising edge and
// outputs are checked 1 ns later, well away from the active edge.
module tb_wb_stage;

    logic        clk;
    logic        resetn;
    logic        ms_to_ws_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc;
    logic        ms_reg_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_alu_result;
    logic [2:0]  ms_load_op;
    logic [31:0] ms_rt_value;
    logic        data_rdata_valid;
    logic        data_rdata_ready;
    logic [31:0] data_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        ws_fwd_valid;
    logic        ws_fwd_pending;
    logic [4:0]  ws_fwd_dest;
    logic [31:0] ws_fwd_data;
    logic [31:0] load_wait_cnt;
    logic [31:0] debug_wb_pc;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;
    logic [31:0] debug_wb_rf_wdata;

    int total = 0;
    int bad   = 0;

    wb_stage #(.CNT_WIDTH(32)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ws_allowin        (ws_allowin),
        .ms_pc             (ms_pc),
        .ms_reg_we         (ms_reg_we),
        .ms_dest           (ms_dest),
        .ms_alu_result     (ms_alu_result),
        .ms_load_op        (ms_load_op),
        .ms_rt_value       (ms_rt_value),
        .data_rdata_valid  (data_rdata_valid),
        .data_rdata_ready  (data_rdata_ready),
        .data_rdata        (data_rdata),
        .rf_wen            (rf_wen),
        .rf_waddr          (rf_waddr),
        .rf_wdata          (rf_wdata),
        .ws_fwd_valid      (ws_fwd_valid),
        .ws_fwd_pending    (ws_fwd_pending),
        .ws_fwd_dest       (ws_fwd_dest),
        .ws_fwd_data       (ws_fwd_data),
        .load_wait_cnt     (load_wait_cnt),
        .debug_wb_pc       (debug_wb_pc),
        .debug_wb_rf_wen   (debug_wb_rf_wen),
        .debug_wb_rf_wnum  (debug_wb_rf_wnum),
        .debug_wb_rf_wdata (debug_wb_rf_wdata)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Comparison point
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic we, input logic [4:0] dest,
                         input logic [31:0] alu, input logic [2:0] op, input logic [31:0] rt);
        ms_to_ws_valid = 1'b1;
        ms_pc          = pc;
        ms_reg_we      = we;
        ms_dest        = dest;
        ms_alu_result  = alu;
        ms_load_op     = op;
        ms_rt_value    = rt;
    endtask

    task automatic idle_ms();
        ms_to_ws_valid = 1'b0;
        ms_pc          = '0;
        ms_reg_we      = 1'b0;
        ms_dest        = '0;
        ms_alu_result  = '0;
        ms_load_op     = '0;
        ms_rt_value    = '0;
    endtask

    task automatic beat(input logic v, input logic [31:0] d);
        data_rdata_valid = v;
        data_rdata       = d;
    endtask

    // Capture a load and answer it in its first WB cycle
    task automatic quick_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] rt, input logic [31:0] d, input logic [4:0] dest,
                              input logic [31:0] exp);
        offer(32'h500, 1'b1, dest, addr, op, rt);
        tick();
        idle_ms();
        beat(1'b1, d);
        #1;
        chk({tag, "_wen"}, 32'(rf_wen), 32'd1);
        chk({tag, "_data"}, rf_wdata, exp);
        tick();
        beat(1'b0, '0);
    endtask

    initial begin
        resetn = 1'b0;
        idle_ms();
        beat(1'b0, '0);
        tick();
        tick();
        #1;
        chk("rst_allowin", 32'(ws_allowin), 32'd1);
        chk("rst_ready", 32'(data_rdata_ready), 32'd0);
        chk("rst_wen", 32'(rf_wen), 32'd0);
        chk("rst_cnt", load_wait_cnt, 32'd0);
        chk("rst_dbg_pc", debug_wb_pc, 32'd0);
        chk("rst_fwd_dest", 32'(ws_fwd_dest), 32'd0);
        chk("rst_wdata", rf_wdata, 32'd0);
        resetn = 1'b1;
        tick();

        // ALU stream, back-to-back
        offer(32'h100, 1'b1, 5'd8, 32'h1234, 3'd0, 32'd0);
        #1;
        chk("alu_allowin0", 32'(ws_allowin), 32'd1);
        tick();
        offer(32'h104, 1'b1, 5'd9, 32'h55, 3'd0, 32'd0);
        #1;
        chk("alu1_wen", 32'(rf_wen), 32'd1);
        chk("alu1_waddr", 32'(rf_waddr), 32'd8);
        chk("alu1_wdata", rf_wdata, 32'h1234);
        chk("alu1_allowin", 32'(ws_allowin), 32'd1);
        chk("alu1_dbg_pc", debug_wb_pc, 32'h100);
        chk("alu1_dbg_wen", 32'(debug_wb_rf_wen), 32'hF);
        chk("alu1_fwd_dest", 32'(ws_fwd_dest), 32'd8);
        chk("alu1_fwd_valid", 32'(ws_fwd_valid), 32'd1);
        tick();
        idle_ms();
        #1;
        chk("alu2_wen", 32'(rf_wen), 32'd1);
        chk("alu2_waddr", 32'(rf_waddr), 32'd9);
        chk("alu2_wdata", rf_wdata, 32'h55);
        chk("alu2_dbg_pc", debug_wb_pc, 32'h104);
        tick();
        #1;
        chk("alu_done_wen", 32'(rf_wen), 32'd0);
        chk("alu_done_allowin", 32'(ws_allowin), 32'd1);

        // Non-writing ALU instruction
        offer(32'h108, 1'b0, 5'd7, 32'h77, 3'd0, 32'd0);
        tick();
        idle_ms();
        #1;
        chk("nowe_wen", 32'(rf_wen), 32'd0);
        chk("nowe_dbg_pc", debug_wb_pc, 32'h108);
        chk("nowe_fwd_valid", 32'(ws_fwd_valid), 32'd0);
        tick();

        // LB sign-extend with two stall cycles
        offer(32'h200, 1'b1, 5'd10, 32'h1002, 3'd2, 32'd0);
        tick();
        idle_ms();
        #1;
        chk("lb_c1_pending", 32'(ws_fwd_pending), 32'd1);
        chk("lb_c1_fwd_valid", 32'(ws_fwd_valid), 32'd0);
        chk("lb_c1_fwd_dest", 32'(ws_fwd_dest), 32'd10);
        chk("lb_c1_allowin", 32'(ws_allowin), 32'd0);
        chk("lb_c1_ready", 32'(data_rdata_ready), 32'd1);
        chk("lb_c1_wen", 32'(rf_wen), 32'd0);
        chk("lb_c1_dbg_pc", debug_wb_pc, 32'd0);
        tick();
        #1;
        chk("lb_c2_pending", 32'(ws_fwd_pending), 32'd1);
        chk("lb_c2_allowin", 32'(ws_allowin), 32'd0);
        chk("lb_c2_cnt", load_wait_cnt, 32'd1);
        tick();
        beat(1'b1, 32'h0080_0000);
        #1;
        chk("lb_c3_wen", 32'(rf_wen), 32'd1);
        chk("lb_c3_waddr", 32'(rf_waddr), 32'd10);
        chk("lb_c3_wdata", rf_wdata, 32'hFFFF_FF80);
        chk("lb_c3_fwd_data", ws_fwd_data, 32'hFFFF_FF80);
        chk("lb_c3_pending", 32'(ws_fwd_pending), 32'd0);
        chk("lb_c3_fwd_valid", 32'(ws_fwd_valid), 32'd1);
        chk("lb_c3_allowin", 32'(ws_allowin), 32'd1);
        chk("lb_c3_cnt", load_wait_cnt, 32'd2);
        chk("lb_c3_dbg_pc", debug_wb_pc, 32'h200);
        tick();
        beat(1'b0, '0);
        #1;
        chk("lb_after_cnt", load_wait_cnt, 32'd2);
        chk("lb_after_ready", 32'(data_rdata_ready), 32'd0);

        // LWL -> LWR -> LHU back-to-back, each answered immediately
        offer(32'h300, 1'b1, 5'd11, 32'h2001, 3'd6, 32'hAABB_CCDD);
        tick();
        offer(32'h304, 1'b1, 5'd12, 32'h2002, 3'd7, 32'hAABB_CCDD);
        beat(1'b1, 32'h1122_3344);
        #1;
        chk("lwl_allowin", 32'(ws_allowin), 32'd1);
        chk("lwl_waddr", 32'(rf_waddr), 32'd11);
        chk("lwl_wdata", rf_wdata, 32'h3344_CCDD);
        tick();
        offer(32'h308, 1'b1, 5'd13, 32'h2002, 3'd5, 32'd0);
        #1;
        chk("lwr_waddr", 32'(rf_waddr), 32'd12);
        chk("lwr_wdata", rf_wdata, 32'hAABB_1122);
        chk("lwr_dbg_pc", debug_wb_pc, 32'h304);
        tick();
        idle_ms();
        #1;
        chk("lhu_waddr", 32'(rf_waddr), 32'd13);
        chk("lhu_wdata", rf_wdata, 32'h0000_1122);
        tick();
        beat(1'b0, '0);
        #1;
        chk("merge_cnt", load_wait_cnt, 32'd2);

        // Further alignment corners
        quick_load("lh_a0",   3'd4, 32'h3000, 32'd0,        32'h1234_8001, 5'd14, 32'hFFFF_8001);
        quick_load("lbu_a3",  3'd3, 32'h3003, 32'd0,        32'h9A00_0000, 5'd15, 32'h0000_009A);
        quick_load("lw",      3'd1, 32'h3004, 32'd0,        32'hCAFE_F00D, 5'd16, 32'hCAFE_F00D);
        quick_load("lwl_a0",  3'd6, 32'h3000, 32'hAABB_CCDD, 32'h1122_3344, 5'd17, 32'h44BB_CCDD);
        quick_load("lwr_a3",  3'd7, 32'h3003, 32'hAABB_CCDD, 32'h1122_3344, 5'd18, 32'hAABB_CC11);
        quick_load("lh_a2",   3'd4, 32'h3002, 32'd0,        32'h8001_0000, 5'd19, 32'hFFFF_8001);

        // LW to $0
        offer(32'h400, 1'b1, 5'd0, 32'h4, 3'd1, 32'd0);
        tick();
        idle_ms();
        beat(1'b1, 32'hDEAD_BEEF);
        #1;
        chk("z_ready", 32'(data_rdata_ready), 32'd1);
        chk("z_wen", 32'(rf_wen), 32'd0);
        chk("z_dbg_wen", 32'(debug_wb_rf_wen), 32'd0);
        chk("z_fwd_valid", 32'(ws_fwd_valid), 32'd0);
        chk("z_fwd_dest", 32'(ws_fwd_dest), 32'd0);
        chk("z_pending", 32'(ws_fwd_pending), 32'd0);
        chk("z_dbg_pc", debug_wb_pc, 32'h400);
        tick();
        beat(1'b0, '0);
        #1;
        chk("z_after_allowin", 32'(ws_allowin), 32'd1);

        // Stray response while EMPTY
        beat(1'b1, 32'h0BAD_0BAD);
        #1;
        chk("stray_ready", 32'(data_rdata_ready), 32'd0);
        chk("stray_wen", 32'(rf_wen), 32'd0);
        chk("stray_dbg_pc", debug_wb_pc, 32'd0);
        tick();
        #1;
        chk("stray_allowin", 32'(ws_allowin), 32'd1);
        chk("stray_cnt", load_wait_cnt, 32'd2);
        beat(1'b0, '0);

        // Reset in the middle of WAIT, then a late response
        offer(32'h600, 1'b1, 5'd20, 32'h8, 3'd1, 32'd0);
        tick();
        idle_ms();
        tick();
        tick();
        #1;
        chk("mid_cnt", load_wait_cnt, 32'd4);
        chk("mid_ready", 32'(data_rdata_ready), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mr_allowin", 32'(ws_allowin), 32'd1);
        chk("mr_ready", 32'(data_rdata_ready), 32'd0);
        chk("mr_wen", 32'(rf_wen), 32'd0);
        chk("mr_cnt", load_wait_cnt, 32'd0);
        chk("mr_fwd_dest", 32'(ws_fwd_dest), 32'd0);
        tick();
        resetn = 1'b1;
        beat(1'b1, 32'h1357_9BDF);
        #1;
        chk("late_ready", 32'(data_rdata_ready), 32'd0);
        chk("late_wen", 32'(rf_wen), 32'd0);
        tick();
        beat(1'b0, '0);
        #1;
        chk("late_allowin", 32'(ws_allowin), 32'd1);
        chk("late_cnt", load_wait_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the five-stage MIPS pipeline; sits between the MEM stage and the register file.
- Holds one retiring instruction and waits for AXI load data when required.
- Aligns and extends load data, including LWL/LWR merge, then drives the register-file write port.
- Provides forwarding/interlock information to ID and the debug trace port.

Parameters:
- CNT_WIDTH, 32, width of the load-wait cycle counter.

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous reset, active low
- ms_to_ws_valid  in  1  MEM stage offers an instruction
- ws_allowin  out  1  WB can accept this cycle
- ms_pc  in  32  PC of offered instruction
- ms_reg_we  in  1  instruction writes a GPR
- ms_dest  in  5  destination GPR
- ms_alu_result  in  32  ALU result, or load address for loads
- ms_load_op  in  3  0 none, 1 LW, 2 LB, 3 LBU, 4 LH, 5 LHU, 6 LWL, 7 LWR
- ms_rt_value  in  32  old rt value for LWL/LWR merge
- data_rdata_valid  in  1  AXI read response beat valid
- data_rdata_ready  out  1  WB accepts read response
- data_rdata  in  32  AXI read data (word-aligned)
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- ws_fwd_valid  out  1  ws_fwd_data valid for ws_fwd_dest
- ws_fwd_pending  out  1  WB holds a load whose data has not arrived; ID must stall on a match
- ws_fwd_dest  out  5  dest of held instruction (0 if none or no write)
- ws_fwd_data  out  32  same value as rf_wdata
- load_wait_cnt  out  CNT_WIDTH  total cycles spent in WAIT
- debug_wb_pc  out  32  retiring PC
- debug_wb_rf_wen  out  4  {4{rf_wen}}
- debug_wb_rf_wnum  out  5  equals rf_waddr
- debug_wb_rf_wdata  out  32  equals rf_wdata

Behaviour:
- States: EMPTY, HOLD (non-load held), WAIT (load held, data not yet received). Registered fields: pc, reg_we, dest, alu_result, load_op, rt_value.
- Reset (async, resetn=0): state EMPTY, load_wait_cnt=0, all registered fields 0. Consequently every output is 0 except ws_allowin=1.
- retire = (HOLD) | (WAIT & data_rdata_valid). ws_allowin = EMPTY | retire. data_rdata_ready = WAIT.
- Capture: at the clock edge with ms_to_ws_valid & ws_allowin, latch the fields and go to HOLD if load_op==0, else WAIT.
- Otherwise: when retire is 1, go to EMPTY; WAIT with no data stays in WAIT.
- Back-to-back: retire and capture in the same cycle is legal; the new instruction overwrites the held one with no bubble.
- Register-file write is combinational in the retire cycle:
  - rf_wen = retire & reg_we & (dest!=0).
  - rf_waddr = dest.
- Non-load write data: rf_wdata = alu_result.
- Load write data, with a = alu_result[1:0] and d = data_rdata:
  - LW: d.
  - LB/LBU: byte d[8a+7:8a], sign/zero-extended.
  - LH/LHU: half d[16a[1]+15:16a[1]], sign/zero-extended; a[0] ignored, since alignment is checked upstream.
  - LWL: a=0 {d[7:0],rt[23:0]}; a=1 {d[15:0],rt[15:0]}; a=2 {d[23:0],rt[7:0]}; a=3 d.
  - LWR: a=0 d; a=1 {rt[31:24],d[31:8]}; a=2 {rt[31:16],d[31:16]}; a=3 {rt[31:8],d[31:24]}.
- Load latency: one-beat response in the first WB cycle → write in that cycle. Each cycle in WAIT without data adds one cycle and increments load_wait_cnt; the counter wraps at 2^CNT_WIDTH.
- Forwarding:
  - ws_fwd_dest = dest when state!=EMPTY & reg_we & dest!=0, else 0.
  - ws_fwd_pending = WAIT & ~data_rdata_valid & ws_fwd_dest!=0.
  - ws_fwd_valid = (ws_fwd_dest!=0) & ~ws_fwd_pending.
- Responses: data_rdata_valid while not in WAIT is ignored and is not consumed.
- Debug port: debug_wb_pc = pc when retire, else 0.
- Reset mid-WAIT: held load is discarded; a late response is not consumed after reset.

Test Plan:
- Reset: assert resetn=0 mid-WAIT → state EMPTY, rf_wen=0, ws_allowin=1, data_rdata_ready=0, load_wait_cnt=0.
- ALU stream: ADDU dest=8 result 0x1234 then dest=9 result 0x55 on consecutive cycles → rf_wen in two consecutive cycles (8←0x1234, 9←0x55); ws_allowin stays 1.
- LB sign-extend: addr low=2, response 0x0080_0000 three cycles after capture → ws_fwd_pending=1 for cycles 1–2; write 0xFFFF_FF80 on cycle 3; load_wait_cnt=2; ws_allowin=0 while waiting.
- LWL/LWR merge: rt=0xAABBCCDD, d=0x11223344. LWL a=1 → 0x3344CCDD; LWR a=2 → 0xAABB1122; LHU a=2 → 0x0000_1122.
- Dest zero: LW dest=0 → response consumed, rf_wen=0, ws_fwd_valid=0, debug_wb_pc still valid.
- Stray response: data_rdata_valid=1 while EMPTY → data_rdata_ready=0, no write, state unchanged.
